// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - central stall/flush scheduler for the 5-stage pipeline
module pipe_stall_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic resetn,
    input  logic lwstallD,
    input  logic imem_stall,
    input  logic dmem_stall,
    input  logic div_req_E,
    input  logic except_M,
    output logic stallF,
    output logic stallD,
    output logic stallE,
    output logic stallM,
    output logic stallW,
    output logic flushD,
    output logic flushE,
    output logic flushM,
    output logic flushW,
    output logic pc_redirect,
    output logic div_start,
    output logic div_done,
    output logic busy_div
);

    typedef enum logic [0:0] {RUN, DIV} state_t;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic       div_ok_q, div_ok_d;

    logic div_issue;
    logic div_hold;
    logic div_fin;

    assign div_issue = (state_q == RUN) && div_req_E && !div_ok_q;
    assign div_hold  = div_issue || ((state_q == DIV) && (cnt_q != 6'd0));
    assign div_fin   = (state_q == DIV) && (cnt_q == 6'd0);
    assign busy_div  = (state_q == DIV);
    assign stallW    = 1'b0;

    always_comb begin
        stallF      = 1'b0;
        stallD      = 1'b0;
        stallE      = 1'b0;
        stallM      = 1'b0;
        flushD      = 1'b0;
        flushE      = 1'b0;
        flushM      = 1'b0;
        flushW      = 1'b0;
        pc_redirect = 1'b0;
        div_start   = 1'b0;
        div_done    = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_ok_d    = div_ok_q;

        if (except_M) begin
            flushD      = 1'b1;
            flushE      = 1'b1;
            flushM      = 1'b1;
            pc_redirect = 1'b1;
            state_d     = RUN;
            cnt_d       = 6'd0;
            div_ok_d    = 1'b0;
        end else begin
            if (dmem_stall) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                stallM = 1'b1;
                flushW = 1'b1;
            end
            if (div_hold) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = !dmem_stall;
            end
            div_start = div_issue;
            div_done  = div_fin;
            // Fetch wait and load-use only act when nothing higher holds the pipe.
            if (!dmem_stall && !div_hold) begin
                stallF = imem_stall || lwstallD;
                stallD = lwstallD;
                flushD = imem_stall && !lwstallD;
                flushE = lwstallD;
            end

            if (div_issue) begin
                state_d = DIV;
                cnt_d   = 6'(DIV_CYCLES - 1);
            end else if (state_q == DIV) begin
                if (cnt_q != 6'd0) begin
                    cnt_d = cnt_q - 6'd1;
                end else begin
                    state_d = RUN;
                end
            end

            // div_ok remembers a finished divide still parked in E.
            if (!stallE) begin
                div_ok_d = 1'b0;
            end else if (div_fin) begin
                div_ok_d = 1'b1;
            end
        end

        if (!resetn) begin
            stallF      = 1'b0;
            stallD      = 1'b0;
            stallE      = 1'b0;
            stallM      = 1'b0;
            flushD      = 1'b1;
            flushE      = 1'b1;
            flushM      = 1'b1;
            flushW      = 1'b1;
            pc_redirect = 1'b0;
            div_start   = 1'b0;
            div_done    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= RUN;
            cnt_q    <= 6'd0;
            div_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_ok_q <= div_ok_d;
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - directed vector bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;

    logic clk = 1'b0;
    logic resetn;
    logic lwstallD, imem_stall, dmem_stall, div_req_E, except_M;
    logic stallF, stallD, stallE, stallM, stallW;
    logic flushD, flushE, flushM, flushW;
    logic pc_redirect, div_start, div_done, busy_div;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.DIV_CYCLES(4)) dut (
        .clk(clk), .resetn(resetn),
        .lwstallD(lwstallD), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .div_req_E(div_req_E), .except_M(except_M),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .pc_redirect(pc_redirect), .div_start(div_start), .div_done(div_done),
        .busy_div(busy_div)
    );

    // Output word: {sF,sD,sE,sM,sW, fD,fE,fM,fW, pc, dstart, ddone, busy}
    typedef struct {
        string      name;
        logic [4:0] in;   // {lw, imem, dmem, div, exc}
        logic [12:0] exp;
    } vec_t;

    function automatic logic [12:0] outs();
        return {stallF, stallD, stallE, stallM, stallW,
                flushD, flushE, flushM, flushW,
                pc_redirect, div_start, div_done, busy_div};
    endfunction

    task automatic drive(input logic [4:0] v);
        {lwstallD, imem_stall, dmem_stall, div_req_E, except_M} = v;
    endtask

    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] got;
        got = outs();
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %013b required %013b", name, got, exp);
        end
        n_cmp++;
        if ((stallD && flushD) || (stallE && flushE) || (stallM && flushM) || (stallW && flushW)) begin
            n_bad++;
            $display("FAIL %s_stall_flush_overlap: got %013b required no stage with both", name, got);
        end
    endtask

    task automatic cyc(input string name, input logic [4:0] v, input logic [12:0] exp);
        @(posedge clk);
        #1;
        drive(v);
        @(negedge clk);
        check(name, exp);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{"idle",       5'b00000, 13'b00000_0000_0000};
        vecs[1] = '{"lw",         5'b10000, 13'b11000_0100_0000};
        vecs[2] = '{"imem",       5'b01000, 13'b10000_1000_0000};
        vecs[3] = '{"lw_imem",    5'b11000, 13'b11000_0100_0000};
        vecs[4] = '{"dmem",       5'b00100, 13'b11110_0001_0000};
        vecs[5] = '{"dmem_lw",    5'b10100, 13'b11110_0001_0000};
        vecs[6] = '{"dmem_all",   5'b11100, 13'b11110_0001_0000};
        vecs[7] = '{"except",     5'b00001, 13'b00000_1110_1000};
        vecs[8] = '{"except_all", 5'b11101, 13'b00000_1110_1000};

        resetn = 1'b0;
        drive(5'b11111);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_forced", 13'b00000_1111_0000);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        drive(5'b00000);
        @(negedge clk);
        check("post_reset_idle", 13'b00000_0000_0000);

        for (int i = 0; i < 9; i++) begin
            cyc(vecs[i].name, vecs[i].in, vecs[i].exp);
        end

        // Plain divide, DIV_CYCLES=4
        cyc("div_c0_start", 5'b00010, 13'b11100_0010_0100);
        for (int c = 1; c < 4; c++) begin
            cyc($sformatf("div_c%0d_busy", c), 5'b00010, 13'b11100_0010_0001);
        end
        cyc("div_c4_done", 5'b00010, 13'b00000_0000_0011);
        cyc("div_c5_idle", 5'b00000, 13'b00000_0000_0000);

        // Completion held by memory wait; no re-issue while parked in E
        cyc("hold_c0_start", 5'b00010, 13'b11100_0010_0100);
        for (int c = 1; c < 4; c++) begin
            cyc($sformatf("hold_c%0d_busy", c), 5'b00010, 13'b11100_0010_0001);
        end
        cyc("hold_c4_done_dmem", 5'b00110, 13'b11110_0001_0011);
        cyc("hold_c5_dmem", 5'b00110, 13'b11110_0001_0000);
        cyc("hold_c6_dmem", 5'b00110, 13'b11110_0001_0000);
        cyc("hold_c7_release", 5'b00010, 13'b00000_0000_0000);

        // Next divide issues once the previous left E, then an exception aborts it
        cyc("exc_c0_start", 5'b00010, 13'b11100_0010_0100);
        cyc("exc_c1_busy", 5'b00010, 13'b11100_0010_0001);
        cyc("exc_c2_except", 5'b00011, 13'b00000_1110_1001);
        cyc("exc_c3_restart", 5'b00010, 13'b11100_0010_0100);
        for (int c = 1; c < 4; c++) begin
            cyc($sformatf("exc_r%0d_busy", c), 5'b00010, 13'b11100_0010_0001);
        end
        cyc("exc_r4_done", 5'b00010, 13'b00000_0000_0011);
        cyc("final_idle", 5'b00000, 13'b00000_0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage MIPS pipeline.
- Merges the hazard unit's load-use stall with instruction-fetch wait, data-memory wait and M-stage exceptions.
- Sequences the multi-cycle divider: issues start, holds E for a fixed latency, then releases the result.
- Drives every per-stage stall/flush enable, so the pipeline registers need no local arbitration.

Parameters:
DIV_CYCLES, 32, divider latency in cycles from div_start to result valid; legal range 2..63.

Ports:
clk  in  1  clock, rising edge
resetn  in  1  synchronous reset, active-low
lwstallD  in  1  load-use stall request from hazard unit
imem_stall  in  1  instruction fetch not complete this cycle
dmem_stall  in  1  data access in M not complete this cycle
div_req_E  in  1  divide instruction resident in E
except_M  in  1  exception detected on instruction in M
stallF  out  1  hold PC
stallD  out  1  hold F/D register
stallE  out  1  hold D/E register
stallM  out  1  hold E/M register
stallW  out  1  hold M/W register (tied 0; present for symmetry)
flushD  out  1  bubble into D
flushE  out  1  bubble into E
flushM  out  1  bubble into M
flushW  out  1  bubble into W
pc_redirect  out  1  PC takes exception vector this cycle
div_start  out  1  single-cycle pulse starting divider
div_done  out  1  divider result valid; E may consume it this cycle
busy_div  out  1  FSM in DIV

Behaviour:
- Reset (resetn=0 at clk edge):
  - state=RUN, cnt=0, div_ok=0.
  - While resetn=0, outputs are forced: all stalls 0, flushD/E/M/W=1, pc_redirect/div_start/div_done=0.
- States: RUN, DIV. cnt is a 6-bit down-counter.
- All outputs are combinational from state, cnt, div_ok and inputs. The only registered elements are state, cnt and div_ok.
- Priority per cycle, highest first: except_M > dmem_stall > divide > imem_stall > lwstallD.
- except_M=1:
  - flushD=flushE=flushM=1, pc_redirect=1, all stalls 0, div_start=0.
  - Next state is RUN, cnt=0, div_ok=0. This aborts any DIV in progress; divider output is ignored.
  - Overrides every other source.
- dmem_stall=1, no exception:
  - stallF=stallD=stallE=stallM=1, flushW=1.
  - In DIV, cnt keeps counting.
- Divide issue, in RUN with div_req_E=1, div_ok=0, no exception:
  - div_start=1, stallF=stallD=stallE=1.
  - flushM=1 unless dmem_stall (then stallM=1 and flushW=1).
  - Next state DIV, cnt=DIV_CYCLES-1.
- DIV with cnt!=0:
  - stallF=stallD=stallE=1, flushM=1 unless dmem_stall.
  - cnt decrements.
- DIV with cnt==0:
  - div_done=1, next state RUN, div_ok=1.
  - Stalls come only from dmem_stall this cycle; E advances at the edge if stallE=0.
  - Result latency: div_done asserts exactly DIV_CYCLES cycles after the div_start cycle.
- div_ok:
  - Set on leaving DIV normally.
  - Cleared on any edge where stallE=0 (the divide has left E) or on exception.
  - Prevents re-issuing a divide whose result was already produced but was held by dmem_stall.
- imem_stall, when no higher source is active:
  - stallF=1.
  - flushD=1 only if stallD=0; otherwise D holds.
- lwstallD, when no higher source is active:
  - stallF=stallD=1.
  - flushE=1 only if stallE=0.
- No source active: all stalls 0, all flushes 0.
- Invariants:
  - A stage's stall and flush are never both 1.
  - div_start is never asserted in DIV.
  - busy_div=1 iff state==DIV.

Test Plan:
- Reset: hold resetn=0 for 2 cycles with all inputs 1 -> flushD/E/M/W=1, stalls=0, div_start=0. First cycle after release with inputs 0 -> all outputs 0.
- Divide, DIV_CYCLES=4: div_req_E=1 at cycle 0 -> div_start=1 at cycle 0 only; stallE=1 in cycles 0-3; div_done=1 and stallE=0 at cycle 4; no second div_start at cycle 5.
- Divide completion held by memory: dmem_stall=1 during cycles 4-6 of the above -> stallE=1 cycles 4-6, div_done only at cycle 4, no re-issue, E advances at end of cycle 7.
- Exception mid-divide: except_M=1 at cycle 2 of DIV -> pc_redirect=1, flushD/E/M=1, busy_div=0 at cycle 3; a new div_req_E then issues div_start again.
- Load-use with fetch wait: lwstallD=1 and imem_stall=1 together -> stallF=stallD=1, flushE=1, flushD=0.
- Memory wait priority: dmem_stall=1 with lwstallD=1 -> stallF/D/E/M=1, flushW=1, flushE=0.
